// File: rtl/int_alu_pipe.sv
// ----------------------------------------------------------------------------
// int_alu_pipe
//   Pipelined integer ALU feeding the Common Data Bus. One op per cycle is
//   accepted from the reservation station. The result is computed
//   combinationally at issue and registered into stage 0. It then moves
//   through STAGES elastic stages to the output stage, where it waits for a
//   CDB grant. Empty slots (bubbles) collapse, so a stalled output stage
//   back-pressures only as far as needed. flush squashes everything in
//   flight.
//
// Parameters
//   DATA_W  operand/result width (>= 8, power of two)
//   TAG_W   destination tag width
//   STAGES  pipeline depth 1..4; this is also the issue-to-CDB latency
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset; clears every stage
//   issue_valid  reservation station presents an op
//   issue_ready  unit accepts the op this cycle (combinational)
//   a, b         operands
//   op           000 add, 001 sub, 010 and, 011 or, 100 xor,
//                101 shl, 110 shr (logical), 111 signed set-less-than
//   dest_tag     destination tag, carried unchanged to the CDB
//   flush        squash all in-flight ops at this edge, including any issue
//   cdb_req      a result is waiting in the output stage
//   cdb_grant    arbiter grants the CDB this cycle
//   cdb_out      {valid, tag, data}; all zeros unless granted, so the outputs
//                of several units can be OR-combined
// ----------------------------------------------------------------------------
module int_alu_pipe #(
    parameter int DATA_W = 16,
    parameter int TAG_W  = 4,
    parameter int STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    input  logic [2:0]            op,
    input  logic [TAG_W-1:0]      dest_tag,
    input  logic                  flush,
    output logic                  cdb_req,
    input  logic                  cdb_grant,
    output logic [DATA_W+TAG_W:0] cdb_out
);

    localparam int SH_W = $clog2(DATA_W);
    localparam int LAST = STAGES - 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    // Add/sub wrap modulo 2^DATA_W. Only the low SH_W bits of b set the
    // shift amount. slt compares both operands as two's complement.
    function automatic logic [DATA_W-1:0] alu_op(
        input logic [2:0]        f,
        input logic [DATA_W-1:0] x,
        input logic [DATA_W-1:0] y
    );
        logic signed [DATA_W-1:0] xs;
        logic signed [DATA_W-1:0] ys;
        logic        [SH_W-1:0]   sh;
        xs     = x;
        ys     = y;
        sh     = y[SH_W-1:0];
        alu_op = '0;
        case (f)
            OP_ADD:  alu_op = x + y;
            OP_SUB:  alu_op = x - y;
            OP_AND:  alu_op = x & y;
            OP_OR:   alu_op = x | y;
            OP_XOR:  alu_op = x ^ y;
            OP_SHL:  alu_op = x << sh;
            OP_SHR:  alu_op = x >> sh;
            OP_SLT:  alu_op = (xs < ys) ? DATA_W'(1) : '0;
            default: alu_op = '0;
        endcase
    endfunction

    logic [STAGES-1:0] vld_p;
    logic [TAG_W-1:0]  tag_p  [STAGES];
    logic [DATA_W-1:0] data_p [STAGES];
    logic [STAGES-1:0] adv;
    logic              issue_fire;
    logic [DATA_W-1:0] alu_res;

    // adv[i]: the content of stage i moves on at this edge. The output stage
    // moves on only when granted. Any other stage moves on when the next
    // stage is empty or itself moving, which lets bubbles collapse.
    always_comb begin : adv_chain
        logic go;
        go        = vld_p[LAST] & cdb_grant;
        adv       = '0;
        adv[LAST] = go;
        for (int i = LAST - 1; i >= 0; i--) begin
            go     = ~vld_p[i+1] | go;
            adv[i] = go;
        end
    end

    // With STAGES=1 this reduces to !vld | cdb_grant.
    assign issue_ready = ~vld_p[0] | adv[0];
    assign issue_fire  = issue_valid & issue_ready;
    assign alu_res     = alu_op(op, a, b);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p <= '0;
            for (int i = 0; i < STAGES; i++) begin
                tag_p[i]  <= '0;
                data_p[i] <= '0;
            end
        end else begin
            // ---- issue -> stage 0
            if (issue_ready) begin
                vld_p[0]  <= issue_fire;
                tag_p[0]  <= dest_tag;
                data_p[0] <= alu_res;
            end
            // ---- stage i-1 -> stage i
            for (int i = 1; i < STAGES; i++) begin
                if (adv[i-1]) begin
                    vld_p[i]  <= vld_p[i-1];
                    tag_p[i]  <= tag_p[i-1];
                    data_p[i] <= data_p[i-1];
                end
            end
            // A flush overrides every load above, including this cycle's issue.
            if (flush) begin
                vld_p <= '0;
            end
        end
    end

    // ---- output stage -> CDB
    assign cdb_req = vld_p[LAST];
    assign cdb_out = adv[LAST] ? {1'b1, tag_p[LAST], data_p[LAST]} : '0;

endmodule

// File: tb/tb_int_alu_pipe.sv
// ----------------------------------------------------------------------------
// tb_int_alu_pipe
//   Drives three copies of int_alu_pipe (STAGES = 1, 2, 4) from the same
//   inputs. Each copy is compared every cycle against an abstract model: an
//   in-order queue of results, with the issue cycle recorded per entry. The
//   head of the queue is on offer once it has aged STAGES-1 cycles. Issue is
//   accepted while fewer than STAGES ops are held, or while the head leaves.
//   The STAGES=2 copy is also checked against hand-computed result values.
// ----------------------------------------------------------------------------
module tb_int_alu_pipe;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic        flush;
    logic        cdb_grant;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic [3:0]  dest_tag;

    logic        ir [3];
    logic        rq [3];
    logic [20:0] co [3];

    int checks;
    int errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int_alu_pipe #(.DATA_W(16), .TAG_W(4), .STAGES(1)) u_s1 (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(ir[0]),
        .a(a), .b(b), .op(op), .dest_tag(dest_tag), .flush(flush),
        .cdb_req(rq[0]), .cdb_grant(cdb_grant), .cdb_out(co[0])
    );

    int_alu_pipe #(.DATA_W(16), .TAG_W(4), .STAGES(2)) u_s2 (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(ir[1]),
        .a(a), .b(b), .op(op), .dest_tag(dest_tag), .flush(flush),
        .cdb_req(rq[1]), .cdb_grant(cdb_grant), .cdb_out(co[1])
    );

    int_alu_pipe #(.DATA_W(16), .TAG_W(4), .STAGES(4)) u_s4 (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(ir[2]),
        .a(a), .b(b), .op(op), .dest_tag(dest_tag), .flush(flush),
        .cdb_req(rq[2]), .cdb_grant(cdb_grant), .cdb_out(co[2])
    );

    typedef struct {
        logic [15:0] data;
        logic [3:0]  tag;
        int          iss;
    } ent_t;

    ent_t mem [3][8];
    int   hd  [3];
    int   cnt [3];
    int   cyc;

    logic [19:0] spot_q [$];
    bit          spot_en;
    logic [15:0] exp1 [8];

    function automatic int depth(input int k);
        return (k == 0) ? 1 : (k == 1) ? 2 : 4;
    endfunction

    function automatic logic [15:0] ref_alu(input logic [2:0] f, input logic [15:0] x,
                                            input logic [15:0] y);
        longint xl;
        longint yl;
        int     sh;
        int     sx;
        int     sy;
        logic [15:0] r;
        xl = longint'(x);
        yl = longint'(y);
        sh = int'(y[3:0]);
        sx = $signed(x);
        sy = $signed(y);
        case (f)
            3'd0:    r = 16'((xl + yl) % 65536);
            3'd1:    r = 16'((xl - yl + 65536) % 65536);
            3'd2:    r = x & y;
            3'd3:    r = x | y;
            3'd4:    r = x ^ y;
            3'd5:    r = 16'((xl * (longint'(1) << sh)) % 65536);
            3'd6:    r = 16'(xl / (longint'(1) << sh));
            default: r = (sx < sy) ? 16'd1 : 16'd0;
        endcase
        return r;
    endfunction

    function automatic bit m_req(input int k);
        if (cnt[k] == 0) return 1'b0;
        return cyc >= mem[k][hd[k]].iss + depth(k) - 1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // One clock cycle: inputs are already applied; check at the falling edge,
    // then advance the model across the rising edge.
    task automatic step();
        bit          acc [3];
        bit          lv  [3];
        logic [15:0] r;
        logic [19:0] e;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            bit          er;
            bit          erdy;
            logic [20:0] eo;
            er   = m_req(k);
            erdy = (cnt[k] < depth(k)) || (er && cdb_grant);
            eo   = (er && cdb_grant) ? {1'b1, mem[k][hd[k]].tag, mem[k][hd[k]].data} : 21'd0;
            chk($sformatf("s%0d_ready@%0d", depth(k), cyc), 32'(ir[k]), 32'(erdy));
            chk($sformatf("s%0d_req@%0d", depth(k), cyc), 32'(rq[k]), 32'(er));
            chk($sformatf("s%0d_cdb@%0d", depth(k), cyc), 32'(co[k]), 32'(eo));
            acc[k] = issue_valid && erdy && !flush;
            lv[k]  = er && cdb_grant;
        end
        if (spot_en && co[1][20]) begin
            if (spot_q.size() == 0) begin
                chk("spot_extra", 32'(co[1]), 32'd0);
            end else begin
                e = spot_q.pop_front();
                chk($sformatf("spot@%0d", cyc), 32'(co[1][19:0]), 32'(e));
            end
        end
        r = ref_alu(op, a, b);
        @(posedge clk);
        cyc++;
        for (int k = 0; k < 3; k++) begin
            if (flush) begin
                cnt[k] = 0;
            end else begin
                if (lv[k]) begin
                    hd[k]  = (hd[k] + 1) % 8;
                    cnt[k] = cnt[k] - 1;
                end
                if (acc[k]) begin
                    mem[k][(hd[k] + cnt[k]) % 8] = '{data: r, tag: dest_tag, iss: cyc};
                    cnt[k] = cnt[k] + 1;
                end
            end
        end
        #1;
    endtask

    task automatic check_idle(input string nm);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_s%0d_ready", nm, depth(k)), 32'(ir[k]), 32'd1);
            chk($sformatf("%s_s%0d_req", nm, depth(k)), 32'(rq[k]), 32'd0);
            chk($sformatf("%s_s%0d_cdb", nm, depth(k)), 32'(co[k]), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] ta [4];
        logic [15:0] tb [4];
        logic [2:0]  to [4];
        logic [15:0] te [4];
        int          r;

        checks = 0;
        errors = 0;
        cyc    = 0;
        for (int k = 0; k < 3; k++) begin
            hd[k]  = 0;
            cnt[k] = 0;
        end
        spot_en     = 1'b0;
        rst         = 1'b1;
        issue_valid = 1'b0;
        flush       = 1'b0;
        cdb_grant   = 1'b1;
        a           = '0;
        b           = '0;
        op          = '0;
        dest_tag    = '0;
        exp1 = '{16'h8004, 16'h7FFE, 16'h0001, 16'h8003,
                 16'h8002, 16'h0008, 16'h1000, 16'h0001};

        // Reset state
        #2;
        check_idle("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        cyc++;
        #1;

        // All eight ops back to back with grant held
        spot_en = 1'b1;
        a = 16'h8001;
        b = 16'h0003;
        for (int i = 0; i < 8; i++) begin
            issue_valid = 1'b1;
            op          = 3'(i);
            dest_tag    = 4'(i);
            spot_q.push_back({4'(i), exp1[i]});
            step();
        end
        issue_valid = 1'b0;
        repeat (5) step();

        // Wrap-around and signed compare corners
        ta = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0001};
        tb = '{16'h0001, 16'h0001, 16'h0001, 16'hFFFF};
        to = '{3'd0, 3'd1, 3'd7, 3'd7};
        te = '{16'h0000, 16'hFFFF, 16'h0001, 16'h0000};
        for (int i = 0; i < 4; i++) begin
            issue_valid = 1'b1;
            a           = ta[i];
            b           = tb[i];
            op          = to[i];
            dest_tag    = 4'(8 + i);
            spot_q.push_back({4'(8 + i), te[i]});
            step();
        end
        issue_valid = 1'b0;
        repeat (5) step();
        chk("spot_left", 32'(spot_q.size()), 32'd0);
        spot_en = 1'b0;

        // Backpressure: no grant while three ops are offered, then release
        cdb_grant = 1'b0;
        for (int i = 0; i < 3; i++) begin
            issue_valid = 1'b1;
            a           = 16'($urandom);
            b           = 16'($urandom);
            op          = 3'($urandom_range(0, 7));
            dest_tag    = 4'(1 + i);
            step();
        end
        issue_valid = 1'b0;
        cdb_grant   = 1'b1;
        repeat (6) step();

        // Flush with ops in flight and an issue in the flush cycle
        cdb_grant = 1'b0;
        for (int i = 0; i < 2; i++) begin
            issue_valid = 1'b1;
            a           = 16'($urandom);
            op          = 3'd0;
            dest_tag    = 4'(4 + i);
            step();
        end
        flush    = 1'b1;
        dest_tag = 4'd7;
        step();
        flush       = 1'b0;
        issue_valid = 1'b0;
        cdb_grant   = 1'b1;
        repeat (6) step();

        // Asynchronous reset between edges with ops in flight
        cdb_grant = 1'b1;
        for (int i = 0; i < 2; i++) begin
            issue_valid = 1'b1;
            a           = 16'($urandom);
            b           = 16'($urandom);
            op          = 3'd4;
            dest_tag    = 4'(9 + i);
            step();
        end
        #2;
        rst = 1'b1;
        #1;
        check_idle("midreset");
        for (int k = 0; k < 3; k++) cnt[k] = 0;
        issue_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < 3; i++) begin
            issue_valid = 1'b1;
            a           = 16'($urandom);
            b           = 16'($urandom);
            op          = 3'd1;
            dest_tag    = 4'(12 + i);
            step();
        end
        issue_valid = 1'b0;
        repeat (6) step();

        // Alternating grant with a continuous issue stream
        for (int i = 0; i < 16; i++) begin
            issue_valid = 1'b1;
            cdb_grant   = i[0];
            a           = 16'($urandom);
            b           = 16'($urandom);
            op          = 3'($urandom_range(0, 7));
            dest_tag    = 4'(i);
            step();
        end
        issue_valid = 1'b0;
        cdb_grant   = 1'b1;
        repeat (6) step();

        // Random traffic with occasional flushes and stalls
        for (int i = 0; i < 400; i++) begin
            issue_valid = ($urandom_range(0, 3) != 0);
            cdb_grant   = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 31) == 0);
            r = int'($urandom_range(0, 7));
            a = (r == 0) ? 16'hFFFF : (r == 1) ? 16'h8000 : 16'($urandom);
            r = int'($urandom_range(0, 7));
            b = (r == 0) ? 16'h0001 : (r == 1) ? 16'h7FFF : 16'($urandom);
            op       = 3'($urandom_range(0, 7));
            dest_tag = 4'($urandom);
            step();
        end
        issue_valid = 1'b0;
        flush       = 1'b0;
        cdb_grant   = 1'b1;
        repeat (6) step();
        check_idle("drained");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
